// File: rtl/matmul_relu_engine.sv
// Sequential N x N matrix multiplier with optional ReLU on each result element.
// One multiply-accumulate per cycle in row-major (i, j) order with inner index k;
// operands and mode flags are captured when a start is accepted in IDLE.
module matmul_relu_engine #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  signed_en,
  input  logic [N*N*DW-1:0]     mat_a,
  input  logic [N*N*DW-1:0]     mat_b,
  output logic [N*N*ACCW-1:0]   mat_p,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(N * N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state;
  state_t state_nx;

  logic [N*N*DW-1:0] a_q;
  logic [N*N*DW-1:0] b_q;
  logic              relu_q;
  logic              signed_q;
  logic [ACCW-1:0]   acc;
  logic [IW-1:0]     i;
  logic [IW-1:0]     j;
  logic [IW-1:0]     k;

  logic [DW-1:0]     a_arr [0:N-1][0:N-1];
  logic [DW-1:0]     b_arr [0:N-1][0:N-1];
  logic [ACCW-1:0]   p_arr [0:N*N-1];

  logic [DW-1:0]          a_el;
  logic [DW-1:0]          b_el;
  logic signed [2*DW-1:0] sprod;
  logic [2*DW-1:0]        uprod;
  logic [ACCW-1:0]        prod_ext;
  logic [ACCW-1:0]        sum;
  logic [ACCW-1:0]        result;
  logic [PW-1:0]          p_idx;
  logic                   last_k;
  logic                   last_mac;

  // Unpack the captured operands and repack the result storage onto the port.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign a_arr[r][c] = a_q[(r*N+c)*DW +: DW];
      assign b_arr[r][c] = b_q[(r*N+c)*DW +: DW];
      assign mat_p[(r*N+c)*ACCW +: ACCW] = p_arr[r*N+c];
    end
  end

  // MAC datapath: product extension by mode, wrapping add, ReLU on the final term.
  always_comb begin
    a_el     = a_arr[i][k];
    b_el     = b_arr[k][j];
    sprod    = (2*DW)'($signed(a_el)) * (2*DW)'($signed(b_el));
    uprod    = (2*DW)'(a_el) * (2*DW)'(b_el);
    prod_ext = signed_q ? ACCW'(sprod) : ACCW'(uprod);
    sum      = acc + prod_ext;
    result   = (relu_q && signed_q && sum[ACCW-1]) ? '0 : sum;
    p_idx    = PW'(i) * PW'(N) + PW'(j);
    last_k   = (k == LAST);
    last_mac = last_k && (i == LAST) && (j == LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: accept in IDLE, leave CALC on the last MAC, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last_mac) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Operand capture, index walk, accumulation and result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      relu_q      <= 1'b0;
      signed_q    <= 1'b0;
      acc         <= '0;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      cycle_count <= '0;
      p_arr       <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q         <= mat_a;
            b_q         <= mat_b;
            relu_q      <= relu_en;
            signed_q    <= signed_en;
            acc         <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            cycle_count <= '0;
          end
        end
        CALC: begin
          cycle_count <= cycle_count + 32'd1;
          if (last_k) begin
            p_arr[p_idx] <= result;
            acc          <= '0;
            k            <= '0;
            if (j == LAST) begin
              j <= '0;
              i <= (i == LAST) ? '0 : i + 1'b1;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            acc <= sum;
            k   <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_relu_engine.sv
// Self-checking bench for matmul_relu_engine: N=2/ACCW=32, N=2/ACCW=16 sharing
// the same stimulus, and an N=3 instance. Expected results come from a plain
// integer matrix-multiply model.
module tb_matmul_relu_engine;

  logic         clk;
  logic         rst;
  logic         start;
  logic         start3;
  logic         relu_en;
  logic         signed_en;
  logic [31:0]  mat_a;
  logic [31:0]  mat_b;
  logic [71:0]  a3;
  logic [71:0]  b3;
  logic [127:0] p2;
  logic [63:0]  p16;
  logic [287:0] p3;
  logic         busy2, done2, busy16, done16, busy3, done3;
  logic [31:0]  cc2, cc16, cc3;

  int tests_run    = 0;
  int tests_failed = 0;

  matmul_relu_engine #(.N(2), .DW(8), .ACCW(32)) dut2 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .signed_en(signed_en),
    .mat_a(mat_a), .mat_b(mat_b), .mat_p(p2), .busy(busy2), .done(done2), .cycle_count(cc2));

  matmul_relu_engine #(.N(2), .DW(8), .ACCW(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .relu_en(relu_en), .signed_en(signed_en),
    .mat_a(mat_a), .mat_b(mat_b), .mat_p(p16), .busy(busy16), .done(done16), .cycle_count(cc16));

  matmul_relu_engine #(.N(3), .DW(8), .ACCW(32)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .relu_en(relu_en), .signed_en(signed_en),
    .mat_a(a3), .mat_b(b3), .mat_p(p3), .busy(busy3), .done(done3), .cycle_count(cc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: element (r,c) of A x B with plain integer arithmetic, reduced to accw bits.
  function automatic logic [63:0] ref_elem(input logic [71:0] a, input logic [71:0] b,
                                           input int n, input int r, input int c,
                                           input bit sgn, input bit relu, input int accw);
    longint     s;
    logic [7:0] ea, eb;
    logic [63:0] m;
    s = 0;
    for (int kk = 0; kk < n; kk++) begin
      ea = a[(r*n+kk)*8 +: 8];
      eb = b[(kk*n+c)*8 +: 8];
      if (sgn) s += longint'($signed(ea)) * longint'($signed(eb));
      else     s += longint'({56'd0, ea}) * longint'({56'd0, eb});
    end
    m = 64'(s);
    if (accw < 64) m = m & ((64'd1 << accw) - 64'd1);
    if (relu && sgn && m[accw-1]) m = '0;
    return m;
  endfunction

  function automatic logic [31:0] pack2(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Waits for the 2x2 engines to be idle, pulses start, and follows the run to done.
  task automatic run_op(output int edges, output int busy_cyc, output int dones);
    int guard;
    edges = 0; busy_cyc = 0; dones = 0; guard = 0;
    @(negedge clk);
    while ((busy2 || done2) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy2) busy_cyc++;
    while (!done2 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy2) busy_cyc++;
      if (done2) dones++;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    tests_run++;
    if (p2 !== '0 || p16 !== '0 || p3 !== '0) begin
      tests_failed++;
      $display("FAIL reset_mat_p got p2=%h p16=%h exp 0", p2, p16);
    end
    tests_run++;
    if ({busy2, done2, busy16, done16, busy3, done3} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags got %b exp 000000", {busy2, done2, busy16, done16, busy3, done3});
    end
    tests_run++;
    if (cc2 !== 32'd0 || cc3 !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_count got %0d/%0d exp 0", cc2, cc3);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known;
    int e, b, d;
    int unsigned kexp [4] = '{7, 10, 15, 22};
    logic [31:0] got;
    mat_a = pack2(1, 2, 3, 4);
    mat_b = pack2(1, 2, 3, 4);
    signed_en = 1'b0; relu_en = 1'b0;
    run_op(e, b, d);
    tests_run++;
    if (e !== 8) begin tests_failed++; $display("FAIL known_done_edge got %0d exp 8", e); end
    tests_run++;
    if (b !== 8) begin tests_failed++; $display("FAIL known_busy_cycles got %0d exp 8", b); end
    tests_run++;
    if (cc2 !== 32'd8) begin tests_failed++; $display("FAIL known_cycle_count got %0d exp 8", cc2); end
    for (int x = 0; x < 4; x++) begin
      got = p2[x*32 +: 32];
      tests_run++;
      if (got !== kexp[x]) begin
        tests_failed++;
        $display("FAIL known_p%0d got %0d exp %0d", x, got, kexp[x]);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL known_done_width got done=%b busy=%b exp 0 0", done2, busy2);
    end
  endtask

  task automatic test_signed;
    int e, b, d;
    logic [31:0] got;
    logic [31:0] exp_norelu [4] = '{32'd5, 32'd6, 32'hFFFF_FFF7, 32'hFFFF_FFF6};
    logic [31:0] exp_relu   [4] = '{32'd5, 32'd6, 32'd0, 32'd0};
    mat_a = pack2(-1, 2, 3, -4);
    mat_b = pack2(1, 2, 3, 4);
    signed_en = 1'b1;
    for (int rl = 0; rl < 2; rl++) begin
      relu_en = rl[0];
      run_op(e, b, d);
      for (int x = 0; x < 4; x++) begin
        got = p2[x*32 +: 32];
        tests_run++;
        if (got !== (rl == 0 ? exp_norelu[x] : exp_relu[x])) begin
          tests_failed++;
          $display("FAIL signed_relu%0d_p%0d got %h exp %h", rl, x, got,
                   rl == 0 ? exp_norelu[x] : exp_relu[x]);
        end
      end
    end
  endtask

  task automatic test_wrap;
    int e, b, d;
    mat_a = '1; mat_b = '1;
    signed_en = 1'b0; relu_en = 1'b1;
    run_op(e, b, d);
    for (int x = 0; x < 4; x++) begin
      tests_run++;
      if (p2[x*32 +: 32] !== 32'h0001_FC02 || p16[x*16 +: 16] !== 16'hFC02) begin
        tests_failed++;
        $display("FAIL wrap_p%0d got %h/%h exp 0001fc02/fc02", x, p2[x*32 +: 32], p16[x*16 +: 16]);
      end
    end
  endtask

  task automatic test_random;
    int e, b, d;
    logic [63:0] exp;
    for (int it = 0; it < 12; it++) begin
      mat_a = $urandom; mat_b = $urandom;
      signed_en = 1'($urandom_range(0, 1));
      relu_en   = 1'($urandom_range(0, 1));
      run_op(e, b, d);
      tests_run++;
      if (e !== 8 || cc2 !== 32'd8 || cc16 !== 32'd8) begin
        tests_failed++;
        $display("FAIL random%0d_timing got edge=%0d cc=%0d/%0d exp 8", it, e, cc2, cc16);
      end
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          exp = ref_elem({40'd0, mat_a}, {40'd0, mat_b}, 2, r, c, signed_en, relu_en, 32);
          tests_run++;
          if (p2[(r*2+c)*32 +: 32] !== exp[31:0]) begin
            tests_failed++;
            $display("FAIL random%0d_p%0d%0d got %h exp %h", it, r, c, p2[(r*2+c)*32 +: 32], exp[31:0]);
          end
          exp = ref_elem({40'd0, mat_a}, {40'd0, mat_b}, 2, r, c, signed_en, relu_en, 16);
          tests_run++;
          if (p16[(r*2+c)*16 +: 16] !== exp[15:0]) begin
            tests_failed++;
            $display("FAIL random%0d_w16_p%0d%0d got %h exp %h", it, r, c, p16[(r*2+c)*16 +: 16], exp[15:0]);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] oa, ob;
    logic        os, orl;
    logic [63:0] exp;
    int dones, done_edge, guard;
    mat_a = $urandom; mat_b = $urandom;
    signed_en = 1'b1; relu_en = 1'b0;
    oa = mat_a; ob = mat_b; os = signed_en; orl = relu_en;
    dones = 0; done_edge = 0; guard = 0;
    @(negedge clk);
    while ((busy2 || done2) && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done2) begin
        dones++;
        if (done_edge == 0) done_edge = e;
      end
      if (e == 3) begin
        start = 1'b1; mat_a = ~mat_a; signed_en = ~signed_en; relu_en = ~relu_en;
      end
      if (e == 4) start = 1'b0;
    end
    tests_run++;
    if (dones !== 1 || done_edge !== 8) begin
      tests_failed++;
      $display("FAIL ignore_done got pulses=%0d edge=%0d exp 1 at 8", dones, done_edge);
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        exp = ref_elem({40'd0, oa}, {40'd0, ob}, 2, r, c, os, orl, 32);
        tests_run++;
        if (p2[(r*2+c)*32 +: 32] !== exp[31:0]) begin
          tests_failed++;
          $display("FAIL ignore_p%0d%0d got %h exp %h", r, c, p2[(r*2+c)*32 +: 32], exp[31:0]);
        end
      end
    end
  endtask

  task automatic test_retention;
    int e, b, d, guard;
    logic [127:0] prev;
    logic [63:0]  exp;
    mat_a = pack2(5, 6, 7, 8); mat_b = pack2(1, 1, 1, 1);
    signed_en = 1'b0; relu_en = 1'b0;
    run_op(e, b, d);
    prev = p2;
    mat_a = pack2(2, 0, 0, 3); mat_b = pack2(9, 4, 2, 1);
    guard = 0;
    @(negedge clk);
    while ((busy2 || done2) && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tests_run++;
    if (p2[127:64] !== prev[127:64]) begin
      tests_failed++;
      $display("FAIL retain_row1 got %h exp %h", p2[127:64], prev[127:64]);
    end
    for (int c = 0; c < 2; c++) begin
      exp = ref_elem({40'd0, mat_a}, {40'd0, mat_b}, 2, 0, c, 1'b0, 1'b0, 32);
      tests_run++;
      if (p2[c*32 +: 32] !== exp[31:0]) begin
        tests_failed++;
        $display("FAIL retain_row0_p%0d got %h exp %h", c, p2[c*32 +: 32], exp[31:0]);
      end
    end
    guard = 0;
    while (!done2 && guard < 100) begin @(posedge clk); #1; guard++; end
    tests_run++;
    if (p2 !== {32'd3, 32'd6, 32'd8, 32'd18}) begin
      tests_failed++;
      $display("FAIL retain_final got %h exp 00000003000000060000000800000012", p2);
    end
  endtask

  task automatic test_back_to_back;
    int e, guard;
    logic [63:0] exp;
    mat_a = pack2(1, 2, 3, 4); mat_b = pack2(4, 3, 2, 1);
    signed_en = 1'b0; relu_en = 1'b0;
    guard = 0;
    @(negedge clk);
    while ((busy2 || done2) && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1;
    @(posedge clk); #1;
    e = 0;
    while (!done2 && e < 100) begin @(posedge clk); #1; e++; end
    tests_run++;
    if (e !== 8) begin tests_failed++; $display("FAIL b2b_first_done got %0d exp 8", e); end
    mat_a = pack2(-2, 5, 1, -3); mat_b = pack2(7, -1, 2, 6);
    signed_en = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_gap got busy=%b done=%b exp 0 0", busy2, done2);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy2 !== 1'b1 || cc2 !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_reaccept got busy=%b cc=%0d exp 1 0", busy2, cc2);
    end
    e = 0;
    while (!done2 && e < 100) begin @(posedge clk); #1; e++; end
    tests_run++;
    if (e !== 8) begin tests_failed++; $display("FAIL b2b_second_done got %0d exp 8", e); end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        exp = ref_elem({40'd0, mat_a}, {40'd0, mat_b}, 2, r, c, 1'b1, 1'b0, 32);
        tests_run++;
        if (p2[(r*2+c)*32 +: 32] !== exp[31:0]) begin
          tests_failed++;
          $display("FAIL b2b_p%0d%0d got %h exp %h", r, c, p2[(r*2+c)*32 +: 32], exp[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int e, b, d, guard, dones;
    logic [63:0] exp;
    mat_a = $urandom | 32'h0101_0101; mat_b = $urandom | 32'h0101_0101;
    signed_en = 1'b0; relu_en = 1'b0;
    guard = 0;
    @(negedge clk);
    while ((busy2 || done2) && guard < 100) begin @(negedge clk); guard++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (p2 !== '0 || p16 !== '0 || {busy2, done2} !== 2'b00 || cc2 !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset_clear got p2=%h busy=%b done=%b cc=%0d exp all 0", p2, busy2, done2, cc2);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin @(posedge clk); #1; if (done2) dones++; end
    tests_run++;
    if (dones !== 0) begin tests_failed++; $display("FAIL midreset_no_done got %0d pulses exp 0", dones); end
    run_op(e, b, d);
    tests_run++;
    if (e !== 8 || cc2 !== 32'd8) begin
      tests_failed++;
      $display("FAIL midreset_rerun_timing got edge=%0d cc=%0d exp 8", e, cc2);
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        exp = ref_elem({40'd0, mat_a}, {40'd0, mat_b}, 2, r, c, 1'b0, 1'b0, 32);
        tests_run++;
        if (p2[(r*2+c)*32 +: 32] !== exp[31:0]) begin
          tests_failed++;
          $display("FAIL midreset_p%0d%0d got %h exp %h", r, c, p2[(r*2+c)*32 +: 32], exp[31:0]);
        end
      end
    end
  endtask

  task automatic test_n3;
    int e, guard;
    logic [63:0] exp;
    for (int x = 0; x < 9; x++) begin
      a3[x*8 +: 8] = (x % 4 == 0) ? 8'd1 : 8'd0;
      b3[x*8 +: 8] = 8'(x + 1);
    end
    signed_en = 1'b0; relu_en = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        a3 = {$urandom, $urandom, 8'($urandom)};
        b3 = {$urandom, $urandom, 8'($urandom)};
        signed_en = 1'b1; relu_en = 1'b1;
      end
      guard = 0;
      @(negedge clk);
      while ((busy3 || done3) && guard < 100) begin @(negedge clk); guard++; end
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      e = 0;
      while (!done3 && e < 100) begin @(posedge clk); #1; e++; end
      tests_run++;
      if (e !== 27 || cc3 !== 32'd27) begin
        tests_failed++;
        $display("FAIL n3_pass%0d_timing got edge=%0d cc=%0d exp 27", pass, e, cc3);
      end
      for (int x = 0; x < 9; x++) begin
        exp = (pass == 0) ? 64'(x + 1)
                          : ref_elem(a3, b3, 3, x / 3, x % 3, 1'b1, 1'b1, 32);
        tests_run++;
        if (p3[x*32 +: 32] !== exp[31:0]) begin
          tests_failed++;
          $display("FAIL n3_pass%0d_p%0d got %h exp %h", pass, x, p3[x*32 +: 32], exp[31:0]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start3 = 1'b0;
    relu_en = 1'b0; signed_en = 1'b0;
    mat_a = '0; mat_b = '0; a3 = '0; b3 = '0;
    test_reset;
    test_known;
    test_signed;
    test_wrap;
    test_random;
    test_ignore_start;
    test_retention;
    test_back_to_back;
    test_reset_mid;
    test_n3;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
